// File: rtl/bcd_adder.sv
// Registered multi-digit packed-BCD adder with decimal carry chain.
// Digits that are not valid BCD still follow the same correction rule and raise invalid.
module bcd_adder #(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  carryin,
  input  logic                  in_valid,
  output logic [4*DIGITS-1:0]   Y,
  output logic                  carryout,
  output logic                  invalid,
  output logic                  out_valid
);

  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] sum_next;
  logic [DIGITS-1:0]   bad_digit;

  assign carry[0] = carryin;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] a_d;
      logic [3:0] b_d;
      logic [4:0] raw;
      logic       over9;

      assign a_d   = A[4*gi +: 4];
      assign b_d   = B[4*gi +: 4];
      assign raw   = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry[gi]};
      assign over9 = (raw > 5'd9);

      // Adding 6 modulo 16 skips the six unused codes and yields the decimal digit.
      assign sum_next[4*gi +: 4] = over9 ? (raw[3:0] + 4'd6) : raw[3:0];
      assign carry[gi+1]         = over9;
      assign bad_digit[gi]       = (a_d > 4'd9) || (b_d > 4'd9);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      carryout  <= 1'b0;
      invalid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y        <= sum_next;
        carryout <= carry[DIGITS];
        invalid  <= |bad_digit;
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder.sv
// Scoreboarded bench for bcd_adder: one-digit and two-digit instances share the stimulus,
// a monitor pops expected results whenever out_valid is seen and checks holds in between.
module tb_bcd_adder;

  typedef struct packed {
    logic [7:0] y;
    logic       co;
    logic       inv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       carryin = 1'b0;
  logic       in_valid = 1'b0;

  logic [3:0] y1;
  logic       co1, inv1, ov1;
  logic [7:0] y2;
  logic       co2, inv2, ov2;

  always #5 clk = ~clk;

  bcd_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .A(a[3:0]), .B(b[3:0]), .carryin(carryin),
    .in_valid(in_valid), .Y(y1), .carryout(co1), .invalid(inv1), .out_valid(ov1)
  );

  bcd_adder #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .A(a), .B(b), .carryin(carryin),
    .in_valid(in_valid), .Y(y2), .carryout(co2), .invalid(inv2), .out_valid(ov2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t last1 = '0;
  exp_t last2 = '0;
  logic exp_ov;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference: treat each nibble as a decimal digit value and apply the
  // "over nine -> add six, carry one" rule with ordinary integers.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cin, input int nd);
    exp_t r;
    int   c;
    int   da, db, s, dig;
    r = '0;
    c = int'(cin);
    for (int i = 0; i < nd; i++) begin
      da = (int'(av) >> (4 * i)) % 16;
      db = (int'(bv) >> (4 * i)) % 16;
      s  = da + db + c;
      if (s > 9) begin
        dig = (s + 6) % 16;
        c   = 1;
      end else begin
        dig = s;
        c   = 0;
      end
      r.y = r.y | 8'((dig % 16) << (4 * i));
      if (da > 9 || db > 9) r.inv = 1'b1;
    end
    r.co = (c != 0);
    return r;
  endfunction

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) exp_ov <= 1'b0;
    else     exp_ov <= in_valid;
  end

  // Monitor: pop on out_valid, otherwise the outputs must hold the last result.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
    end
    check("d1 out_valid", {7'b0, ov1}, {7'b0, exp_ov});
    check("d2 out_valid", {7'b0, ov2}, {7'b0, exp_ov});
    if (ov1) begin
      if (q1.size() == 0) check("d1 unexpected result", 8'd1, 8'd0);
      else last1 = q1.pop_front();
      $display("d1 result y=%h co=%b inv=%b", y1, co1, inv1);
    end
    if (ov2) begin
      if (q2.size() == 0) check("d2 unexpected result", 8'd1, 8'd0);
      else last2 = q2.pop_front();
      $display("d2 result y=%h co=%b inv=%b", y2, co2, inv2);
    end
    check("d1 Y", {4'b0, y1}, last1.y);
    check("d1 carryout", {7'b0, co1}, {7'b0, last1.co});
    check("d1 invalid", {7'b0, inv1}, {7'b0, last1.inv});
    check("d2 Y", y2, last2.y);
    check("d2 carryout", {7'b0, co2}, {7'b0, last2.co});
    check("d2 invalid", {7'b0, inv2}, {7'b0, last2.inv});
  end

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    #1;
    a        = av;
    b        = bv;
    carryin  = cv;
    in_valid = 1'b1;
    q1.push_back(model(av, bv, cv, 1));
    q2.push_back(model(av, bv, cv, 2));
    $display("issue a=%h b=%h cin=%b", av, bv, cv);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      carryin  = 1'($urandom);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset d2 Y", y2, 8'h00);
    check("reset d2 carryout", {7'b0, co2}, 8'h00);
    check("reset d2 out_valid", {7'b0, ov2}, 8'h00);
    #1 rst = 1'b0;

    issue(8'h00, 8'h00, 1'b0); idle(1);
    issue(8'h01, 8'h01, 1'b0); idle(1);
    issue(8'h03, 8'h05, 1'b0); idle(1);
    issue(8'h06, 8'h01, 1'b0); idle(1);
    issue(8'h05, 8'h05, 1'b0);
    issue(8'h07, 8'h05, 1'b0);
    issue(8'h06, 8'h08, 1'b0);
    issue(8'h09, 8'h09, 1'b0);
    issue(8'h09, 8'h09, 1'b1);
    issue(8'h00, 8'h09, 1'b1);
    issue(8'h0A, 8'h00, 1'b0);
    issue(8'h02, 8'h03, 1'b0);
    issue(8'h99, 8'h01, 1'b0);
    issue(8'h45, 8'h38, 1'b0);
    issue(8'h99, 8'h99, 1'b1);
    idle(3);
    for (int i = 0; i < 4; i++) issue({rand_digit(), rand_digit()}, {rand_digit(), rand_digit()}, 1'($urandom));

    // Reset between edges while a result is being presented.
    issue(8'h47, 8'h26, 1'b1);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async rst d2 Y", y2, 8'h00);
    check("async rst d2 carryout", {7'b0, co2}, 8'h00);
    check("async rst d2 invalid", {7'b0, inv2}, 8'h00);
    check("async rst d2 out_valid", {7'b0, ov2}, 8'h00);
    check("async rst d1 Y", {4'b0, y1}, 8'h00);
    check("async rst d1 out_valid", {7'b0, ov1}, 8'h00);
    @(negedge clk);
    #1 rst = 1'b0;
    issue(8'h58, 8'h17, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue({rand_digit(), rand_digit()}, {rand_digit(), rand_digit()}, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    check("d1 queue drained", 8'(q1.size()), 8'd0);
    check("d2 queue drained", 8'(q2.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_adder.md
Name: bcd_adder

Overview:
- Registered multi-digit packed-BCD adder with carry-in and carry-out.
- Each 4-bit digit is added with decimal correction: binary sum, then +6 if the digit sum exceeds 9, with ripple carry from least to most significant digit.
- Results are registered on the clock; used as the decimal arithmetic stage in datapaths.
- Also flags non-BCD operand digits.

Parameters:
- DIGITS, default 1: number of BCD digits per operand; must be ≥1. Operand width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  4*DIGITS  packed BCD operand A; digit 0 in bits [3:0].
- B  input  4*DIGITS  packed BCD operand B; same packing as A.
- carryin  input  1  decimal carry into digit 0.
- in_valid  input  1  operands valid this cycle; capture enable.
- Y  output  4*DIGITS  registered packed BCD sum.
- carryout  output  1  registered decimal carry out of the most significant digit.
- invalid  output  1  registered; 1 if any A or B digit captured with the result was >9.
- out_valid  output  1  registered; 1 for the cycle after an in_valid capture.

Behaviour:
- Reset:
  - While rst=1, regardless of clk: Y=0, carryout=0, invalid=0, out_valid=0.
  - Asserting rst mid-operation discards any pending result.
  - The first capture is possible on the first rising edge with rst=0.
- Per-digit arithmetic, combinational, for digit i:
  - c0 = carryin.
  - s_i = A_i + B_i + c_i, computed as 5-bit unsigned.
  - If s_i > 9: Y_i = (s_i + 6) mod 16, c_(i+1) = 1.
  - Else: Y_i = s_i, c_(i+1) = 0.
  - carryout = c_DIGITS.
- Non-BCD digits (value 10..15):
  - The same rule is applied unchanged, so the result is deterministic.
  - invalid is set; no saturation.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1:
  - Y, carryout and invalid load the combinational result of the current A, B, carryin.
  - out_valid <= 1.
- On a rising edge with in_valid=0:
  - Y, carryout and invalid hold their values.
  - out_valid <= 0.
- Throughput is one addition per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure; the consumer must take the result while out_valid=1.
- Range: for valid inputs, the maximum result is 9..9 + 9..9 + 1 = 1 9..9, so carryout=1 with all digits 9.
- There are no X-propagating paths; all outputs are defined after reset.

Test Plan:
- Reset, then DIGITS=1, carryin=0, in_valid pulses:
  - 0+0 -> carryout=0, Y=0.
  - 1+1 -> 0, 2.
  - 3+5 -> 0, 8.
  - 6+1 -> 0, 7.
  - Check out_valid=1 exactly one cycle after each capture.
- DIGITS=1 correction cases:
  - 5+5 -> carryout=1, Y=0.
  - 7+5 -> 1, 2.
  - 6+8 -> 1, 4.
  - 9+9 -> 1, 8.
  - 9+9 with carryin=1 -> 1, 9.
  - 0+9 with carryin=1 -> 1, 0.
- Non-BCD: A=4'hA, B=0, carryin=0 -> Y=0, carryout=1, invalid=1. A following valid add 2+3 -> Y=5, invalid=0.
- DIGITS=2:
  - A=8'h99, B=8'h01 -> Y=8'h00, carryout=1.
  - A=8'h45, B=8'h38 -> Y=8'h83, carryout=0.
- Hold and stream:
  - in_valid low for 3 cycles -> Y holds, out_valid=0.
  - 4 back-to-back in_valid adds -> 4 consecutive out_valid with the matching sums.
- Async reset: assert rst between clock edges while out_valid=1 -> Y, carryout, invalid and out_valid go to 0 immediately. After release, the next capture works normally.
